// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer: reset/interrupt vector loads, branch, stall, increment
// Optional misalignment trap on odd branch targets is built when PC_MISALIGN_TRAP_EN is defined.
module pc_sequencer #(
  parameter int          PC_W           = 32,
  parameter int unsigned INC            = 1,
  parameter int unsigned RESET_VEC_ADDR = 0,
  parameter int unsigned INT_VEC_ADDR   = 1,
  parameter int unsigned EXC_ADDR       = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            int_req_i,
  input  logic [PC_W-1:0] vec_data_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] vec_addr_o,
  output logic            vec_rd_o,
  output logic            flush_o,
  output logic            int_ack_o,
  output logic [PC_W-1:0] epc_o,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign_err_o,
`endif
  output logic            busy_o
);

  typedef enum logic [2:0] {
    RST_ADDR = 3'd0,
    RST_LOAD = 3'd1,
    RUN      = 3'd2,
    INT_ADDR = 3'd3,
    INT_LOAD = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            int_pending_q, int_pending_d;
  logic            int_accept;

  // An interrupt (latched or live) is taken only in RUN when no branch or stall outranks it.
  assign int_accept = (state_q == RUN) && !branch_taken_i && !stall_i &&
                      (int_pending_q || int_req_i);

`ifndef PC_MISALIGN_TRAP_EN
  logic unused_exc_addr;
  assign unused_exc_addr = ^PC_W'(EXC_ADDR);
`endif

  // State, pc, epc and interrupt-pending registers; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= RST_ADDR;
      pc_q          <= '0;
      epc_q         <= '0;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      int_pending_q <= int_pending_d;
    end
  end

  // Next-state and next-pc selection following the RUN priority order.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    // A request that is not accepted this cycle is remembered until it is.
    int_pending_d = int_pending_q || int_req_i;
    case (state_q)
      RST_ADDR: state_d = RST_LOAD;
      RST_LOAD: begin
        pc_d    = vec_data_i;
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken_i) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (branch_target_i[0]) begin
            pc_d  = PC_W'(EXC_ADDR);
            epc_d = branch_target_i;
          end else begin
            pc_d  = branch_target_i;
          end
`else
          pc_d = branch_target_i;
`endif
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (int_accept) begin
          epc_d         = pc_q;
          int_pending_d = 1'b0;
          state_d       = INT_ADDR;
        end else begin
          pc_d = pc_q + PC_W'(INC);
        end
      end
      INT_ADDR: state_d = INT_LOAD;
      INT_LOAD: begin
        pc_d    = vec_data_i;
        state_d = RUN;
      end
      default: state_d = RST_ADDR;
    endcase
  end

  // Combinational strobes; all quiet while reset is asserted.
  always_comb begin
    vec_rd_o   = 1'b0;
    vec_addr_o = '0;
    flush_o    = 1'b0;
    int_ack_o  = 1'b0;
    busy_o     = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_err_o = 1'b0;
`endif
    if (!reset_i) begin
      case (state_q)
        RST_ADDR: begin
          vec_rd_o   = 1'b1;
          vec_addr_o = PC_W'(RESET_VEC_ADDR);
        end
        RST_LOAD: flush_o = 1'b1;
        RUN: begin
          busy_o = 1'b0;
          if (branch_taken_i) begin
            flush_o = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_err_o = branch_target_i[0];
`endif
          end else if (int_accept) begin
            flush_o   = 1'b1;
            int_ack_o = 1'b1;
          end
        end
        INT_ADDR: begin
          vec_rd_o   = 1'b1;
          vec_addr_o = PC_W'(INT_VEC_ADDR);
          flush_o    = 1'b1;
        end
        INT_LOAD: flush_o = 1'b1;
        default: flush_o = 1'b0;
      endcase
    end
  end

  assign pc_o  = pc_q;
  assign epc_o = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and random bench for pc_sequencer against a queue-based reference model
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i, stall_i, branch_taken_i, int_req_i;
  logic [31:0] branch_target_i, vec_data_i;
  logic [31:0] pc_o, vec_addr_o, epc_o;
  logic        vec_rd_o, flush_o, int_ack_o, busy_o;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_err_o;
`endif

  always #5 clk_i = ~clk_i;

  pc_sequencer dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .int_req_i       (int_req_i),
    .vec_data_i      (vec_data_i),
    .pc_o            (pc_o),
    .vec_addr_o      (vec_addr_o),
    .vec_rd_o        (vec_rd_o),
    .flush_o         (flush_o),
    .int_ack_o       (int_ack_o),
    .epc_o           (epc_o),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_err_o  (misalign_err_o),
`endif
    .busy_o          (busy_o)
  );

  // One entry per forced (non-RUN) cycle: expected strobes and which vector gets loaded.
  typedef struct {
    bit          rd;
    logic [31:0] addr;
    bit          fl;
    int          load;   // 0 none, 1 reset vector, 2 interrupt vector
  } step_t;

  step_t       plan[$];
  logic [31:0] m_pc, m_epc;
  bit          m_pend;
  logic [31:0] rst_vec, int_vec;
  logic [31:0] mem_addr;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks outputs at the falling edge, then advances the model past the rising edge.
  task automatic cycle(input bit do_chk);
    bit          e_rd, e_fl, e_ack, e_busy, e_merr, pop, push_rst, push_int;
    logic [31:0] e_addr, n_pc, n_epc;
    bit          n_pend;
    step_t       e;
    @(negedge clk_i);
    e_rd = 0; e_fl = 0; e_ack = 0; e_busy = 1; e_merr = 0; e_addr = 0;
    pop = 0; push_rst = 0; push_int = 0;
    n_pc = m_pc; n_epc = m_epc; n_pend = m_pend || int_req_i;
    if (reset_i) begin
      n_pc = 0; n_epc = 0; n_pend = 0; push_rst = 1;
    end else if (plan.size() > 0) begin
      e = plan[0];
      e_rd = e.rd; e_addr = e.addr; e_fl = e.fl; pop = 1;
      if (e.load == 1) n_pc = rst_vec;
      if (e.load == 2) n_pc = int_vec;
    end else begin
      e_busy = 0;
      if (branch_taken_i) begin
        e_fl = 1;
        n_pc = branch_target_i;
`ifdef PC_MISALIGN_TRAP_EN
        if (branch_target_i[0]) begin
          n_pc = 32'd2; n_epc = branch_target_i; e_merr = 1;
        end
`endif
      end else if (stall_i) begin
        n_pc = m_pc;
      end else if (m_pend || int_req_i) begin
        e_ack = 1; e_fl = 1; n_epc = m_pc; n_pend = 0; push_int = 1;
      end else begin
        n_pc = m_pc + 32'd1;
      end
    end
    if (do_chk) begin
      chk("pc", pc_o, m_pc);
      chk("epc", epc_o, m_epc);
      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("vec_rd", 32'(vec_rd_o), 32'(e_rd));
      chk("flush", 32'(flush_o), 32'(e_fl));
      chk("int_ack", 32'(int_ack_o), 32'(e_ack));
      if (e_rd) chk("vec_addr", vec_addr_o, e_addr);
`ifdef PC_MISALIGN_TRAP_EN
      chk("misalign_err", 32'(misalign_err_o), 32'(e_merr));
`endif
    end
    mem_addr = vec_addr_o;
    @(posedge clk_i);
    #1;
    m_pc = n_pc; m_epc = n_epc; m_pend = n_pend;
    if (push_rst) begin
      plan.delete();
      plan.push_back('{1'b1, 32'd0, 1'b0, 0});
      plan.push_back('{1'b0, 32'd0, 1'b1, 1});
    end
    if (pop) void'(plan.pop_front());
    if (push_int) begin
      plan.push_back('{1'b1, 32'd1, 1'b1, 0});
      plan.push_back('{1'b0, 32'd0, 1'b1, 2});
    end
    // Instruction memory answers one cycle after the address is presented.
    vec_data_i = (mem_addr == 32'd0) ? rst_vec :
                 (mem_addr == 32'd1) ? int_vec : {16'hDEAD, mem_addr[15:0]};
  endtask

  initial begin
    reset_i = 1; stall_i = 0; branch_taken_i = 0; int_req_i = 0;
    branch_target_i = 0; vec_data_i = 0;
    rst_vec = 32'h40; int_vec = 32'h300; m_pc = 0; m_epc = 0; m_pend = 0;

    // Reset vector load
    cycle(0);
    cycle(1);
    reset_i = 0;
    cycle(1);
    cycle(1);
    chk("boot_pc", pc_o, 32'h40);
    chk("boot_busy", 32'(busy_o), 32'd0);
    cycle(1);
    cycle(1);
    chk("boot_inc", pc_o, 32'h42);

    // Stall versus branch
    branch_taken_i = 1; branch_target_i = 32'h50;
    cycle(1);
    branch_taken_i = 0; stall_i = 1;
    repeat (3) cycle(1);
    chk("stall_hold", pc_o, 32'h50);
    branch_taken_i = 1; branch_target_i = 32'h200;
    cycle(1);
    chk("branch_over_stall", pc_o, 32'h200);

    // Interrupt pulse under stall
    branch_taken_i = 0; int_req_i = 1;
    cycle(1);
    int_req_i = 0;
    cycle(1);
    stall_i = 0;
    cycle(1);
    chk("int_epc", epc_o, 32'h200);
    repeat (2) cycle(1);
    chk("isr_pc", pc_o, 32'h300);
    cycle(1);

    // Reset while loading the interrupt vector
    int_req_i = 1;
    cycle(1);
    int_req_i = 0;
    cycle(1);
    reset_i = 1;
    cycle(1);
    chk("rst_mid_epc", epc_o, 32'd0);
    reset_i = 0;
    repeat (6) cycle(1);

    // Wrap-around
    branch_taken_i = 1; branch_target_i = 32'hFFFF_FFFF;
    cycle(1);
    branch_taken_i = 0;
    cycle(1);
    chk("wrap_pc", pc_o, 32'h0);

`ifdef PC_MISALIGN_TRAP_EN
    branch_taken_i = 1; branch_target_i = 32'h101;
    cycle(1);
    branch_taken_i = 0;
    chk("trap_pc", pc_o, 32'd2);
    chk("trap_epc", epc_o, 32'h101);
    cycle(1);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset_i         = ($urandom_range(0, 99) < 2);
      stall_i         = ($urandom_range(0, 99) < 30);
      branch_taken_i  = ($urandom_range(0, 99) < 15);
      int_req_i       = ($urandom_range(0, 99) < 10);
      branch_target_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                    : $urandom;
      if (plan.size() == 0) begin
        int_vec = $urandom;
        rst_vec = $urandom;
      end
      cycle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
